daq_frame_packer: RTL and testbench

Parametrised successor to the single-AD7606 packetizer. It generates conversion triggers and runs the busy handshake and chip-select/read sequencing for N_DEV AD7606 devices sharing one data bus, all in one clock domain. Samples are framed as preamble, sequence number, samples and checksum, then written word-by-word into a downstream FIFO. A frame is emitted only when the FIFO has room for the whole frame; otherwise it is dropped and counted.

---
 rtl/daq_pkg.sv | 31 +++
 rtl/daq_trig_gen.sv | 41 ++++
 rtl/daq_frame_packer.sv | 226 ++++++++++++++++++++++
 tb/tb_daq_frame_packer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
// Shared types and constants for the AD7606 frame packer.
// Holds the FSM state enum, default preamble, frame length and error bits.
package daq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CONV,
        WAIT_BH,
        WAIT_BL,
        CHECK,
        HDR,
        SEQ,
        RD_L,
        RD_H,
        CSUM
    } state_t;

    localparam logic [15:0] DEF_PREAMBLE = 16'hAAAA;

    localparam int ERR_BUSY = 0;
    localparam int ERR_FRST = 1;

    function automatic int frame_len(input int n_dev, input int n_ch);
        return n_dev * n_ch + 3;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/daq_trig_gen.sv
// Trigger source: internal period counter or synchronised external edge.
// Ports: clk_i, reset_n_i, en_i, trig_mode_i, ext_trig_i in; trig_o pulse out.
module daq_trig_gen #(
    parameter int CONV_DIV = 1000
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic en_i,
    input  logic trig_mode_i,
    input  logic ext_trig_i,
    output logic trig_o
);

    localparam int CW = (CONV_DIV > 1) ? $clog2(CONV_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CONV_DIV - 1);

    logic [CW-1:0] div_q;
    // [0],[1] synchroniser, [2] previous value for edge detect
    logic [2:0]    sync_q;
    logic          int_fire;
    logic          ext_fire;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_q  <= '0;
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], ext_trig_i};
            if (!en_i || div_q == DIV_LAST) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign int_fire = (div_q == DIV_LAST);
    assign ext_fire = sync_q[1] & ~sync_q[2];
    assign trig_o   = en_i & (trig_mode_i ? ext_fire : int_fire);

endmodule

// File: rtl/daq_frame_packer.sv
// Multi-device AD7606 sequencer framing samples into a downstream FIFO.
// Ports: trigger ctl, AD7606 convst/busy/frstdata/cs_n/rd_n/db, FIFO wr/data/space, status.
module daq_frame_packer
    import daq_pkg::*;
#(
    parameter int              N_DEV     = 1,
    parameter int              N_CH      = 8,
    parameter int              DW        = 16,
    parameter logic [DW-1:0]   PREAMBLE  = DW'(DEF_PREAMBLE),
    parameter int              CONV_DIV  = 1000,
    parameter int              CONVST_LO = 4,
    parameter int              RD_LO     = 4,
    parameter int              RD_HI     = 4,
    parameter int              BUSY_TO   = 1024,
    parameter int              SPW       = 10
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             en_i,
    input  logic             trig_mode_i,
    input  logic             ext_trig_i,
    output logic             convst_o,
    input  logic [N_DEV-1:0] busy_i,
    input  logic [N_DEV-1:0] frstdata_i,
    output logic [N_DEV-1:0] cs_n_o,
    output logic             rd_n_o,
    input  logic [DW-1:0]    db_i,
    input  logic [SPW-1:0]   space_i,
    output logic             wr_o,
    output logic [DW-1:0]    data_o,
    output logic [15:0]      drop_cnt_o,
    output logic [1:0]       err_o
);

    localparam int FLEN = frame_len(N_DEV, N_CH);
    localparam int DVW  = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [DVW-1:0] DEV_LAST = DVW'(N_DEV - 1);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(N_CH - 1);
    localparam logic [15:0] T_CONV = 16'(CONVST_LO - 1);
    localparam logic [15:0] T_RDL  = 16'(RD_LO - 1);
    localparam logic [15:0] T_RDH  = 16'(RD_HI - 1);
    localparam logic [15:0] T_BUSY = 16'(BUSY_TO - 1);

    state_t           state_q, state_d;
    logic [15:0]      tmr_q, tmr_d;
    logic [DVW-1:0]   dev_q, dev_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [15:0]      seq_q, seq_d;
    logic [15:0]      fseq_q, fseq_d;
    logic [DW-1:0]    csum_q, csum_d;
    logic [15:0]      drop_d;
    logic [1:0]       err_d;
    logic             convst_d, rd_d, wr_d;
    logic [N_DEV-1:0] cs_d;
    logic [DW-1:0]    data_d;
    logic             trig;
    logic             fits;
    logic             frst_sel;

    daq_trig_gen #(
        .CONV_DIV (CONV_DIV)
    ) u_trig (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .en_i        (en_i),
        .trig_mode_i (trig_mode_i),
        .ext_trig_i  (ext_trig_i),
        .trig_o      (trig)
    );

    assign fits = 32'(space_i) >= 32'(FLEN);

    always_comb begin
        frst_sel = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            if (dev_q == DVW'(i)) frst_sel = frstdata_i[i];
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 16'd1;
        dev_d   = dev_q;
        ch_d    = ch_q;
        seq_d   = seq_q;
        fseq_d  = fseq_q;
        csum_d  = csum_q;
        drop_d  = drop_cnt_o;
        err_d   = err_o;
        wr_d    = 1'b0;
        data_d  = data_o;
        // a trigger arriving while busy with a frame is lost
        if (trig && state_q != IDLE) drop_d = sat_inc(drop_d);
        unique case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (trig) begin
                    state_d = CONV;
                    fseq_d  = seq_q;
                    seq_d   = seq_q + 16'd1;
                    csum_d  = DW'(seq_q);
                end
            end
            CONV: begin
                if (tmr_q == T_CONV) begin
                    state_d = WAIT_BH;
                    tmr_d   = '0;
                end
            end
            WAIT_BH: begin
                if (&busy_i) begin
                    state_d = WAIT_BL;
                    tmr_d   = '0;
                end else if (tmr_q == T_BUSY) begin
                    state_d         = IDLE;
                    err_d[ERR_BUSY] = 1'b1;
                end
            end
            WAIT_BL: begin
                if (~|busy_i) begin
                    state_d = CHECK;
                end else if (tmr_q == T_BUSY) begin
                    state_d         = IDLE;
                    err_d[ERR_BUSY] = 1'b1;
                end
            end
            CHECK: begin
                if (fits) begin
                    state_d = HDR;
                    wr_d    = 1'b1;
                    data_d  = PREAMBLE;
                end else begin
                    state_d = IDLE;
                    drop_d  = sat_inc(drop_d);
                end
            end
            HDR: begin
                state_d = SEQ;
                wr_d    = 1'b1;
                data_d  = DW'(fseq_q);
            end
            SEQ: begin
                state_d = RD_L;
                tmr_d   = '0;
                dev_d   = '0;
                ch_d    = '0;
            end
            RD_L: begin
                if (tmr_q == T_RDL) begin
                    state_d = RD_H;
                    tmr_d   = '0;
                    wr_d    = 1'b1;
                    data_d  = db_i;
                    csum_d  = csum_q + db_i;
                    if (ch_q == '0 && !frst_sel) err_d[ERR_FRST] = 1'b1;
                end
            end
            RD_H: begin
                if (tmr_q == T_RDH) begin
                    state_d = RD_L;
                    tmr_d   = '0;
                    if (ch_q == CH_LAST) begin
                        ch_d = '0;
                        if (dev_q == DEV_LAST) begin
                            state_d = CSUM;
                            wr_d    = 1'b1;
                            data_d  = csum_q;
                        end else begin
                            dev_d = dev_q + 1'b1;
                        end
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            CSUM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // strobes follow the next state so they are registered outputs
        convst_d = (state_d != CONV);
        rd_d     = (state_d != RD_L);
        for (int i = 0; i < N_DEV; i++) begin
            cs_d[i] = !((state_d == RD_L || state_d == RD_H) && dev_d == DVW'(i));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            dev_q      <= '0;
            ch_q       <= '0;
            seq_q      <= '0;
            fseq_q     <= '0;
            csum_q     <= '0;
            drop_cnt_o <= '0;
            err_o      <= '0;
            convst_o   <= 1'b1;
            cs_n_o     <= '1;
            rd_n_o     <= 1'b1;
            wr_o       <= 1'b0;
            data_o     <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            dev_q      <= dev_d;
            ch_q       <= ch_d;
            seq_q      <= seq_d;
            fseq_q     <= fseq_d;
            csum_q     <= csum_d;
            drop_cnt_o <= drop_d;
            err_o      <= err_d;
            convst_o   <= convst_d;
            cs_n_o     <= cs_d;
            rd_n_o     <= rd_d;
            wr_o       <= wr_d;
            data_o     <= data_d;
        end
    end

endmodule

// File: tb/tb_daq_frame_packer.sv
// Directed/randomised bench for daq_frame_packer with an AD7606 bus model.
// Frames are compared against a reference built from the captured samples.
module tb_daq_frame_packer;

    localparam int N_DEV   = 2;
    localparam int N_CH    = 8;
    localparam int DW      = 16;
    localparam int SPW     = 10;
    localparam int BUSY_TO = 1024;
    localparam int FLEN    = N_DEV * N_CH + 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic             ext = 1'b0;
    logic             convst;
    logic [N_DEV-1:0] busy = '0;
    logic [N_DEV-1:0] frst;
    logic [N_DEV-1:0] cs_n;
    logic             rd_n;
    logic [DW-1:0]    db;
    logic [SPW-1:0]   space = 10'd1023;
    logic             wr;
    logic [DW-1:0]    data;
    logic [15:0]      drop;
    logic [1:0]       err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    daq_frame_packer #(
        .N_DEV     (N_DEV),
        .N_CH      (N_CH),
        .DW        (DW),
        .PREAMBLE  (16'hAAAA),
        .CONV_DIV  (400),
        .CONVST_LO (4),
        .RD_LO     (4),
        .RD_HI     (4),
        .BUSY_TO   (BUSY_TO),
        .SPW       (SPW)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .en_i        (en),
        .trig_mode_i (mode),
        .ext_trig_i  (ext),
        .convst_o    (convst),
        .busy_i      (busy),
        .frstdata_i  (frst),
        .cs_n_o      (cs_n),
        .rd_n_o      (rd_n),
        .db_i        (db),
        .space_i     (space),
        .wr_o        (wr),
        .data_o      (data),
        .drop_cnt_o  (drop),
        .err_o       (err)
    );

    // AD7606 bus model: fresh random samples per conversion
    logic [15:0] samp [N_DEV][N_CH] = '{default: '0};
    int          ch_ptr [N_DEV] = '{default: 0};
    int          bcnt = 0;
    logic        cv_q = 1'b1;
    logic        rd_q = 1'b1;
    bit          stuck = 1'b0;
    bit          corrupt = 1'b0;

    always @(posedge clk) begin
        cv_q <= convst;
        rd_q <= rd_n;
        if (cv_q && !convst) begin
            bcnt <= 1;
            for (int d = 0; d < N_DEV; d++) begin
                ch_ptr[d] <= 0;
                for (int c = 0; c < N_CH; c++) samp[d][c] <= 16'($urandom);
            end
        end else if (bcnt != 0 && bcnt < 40) begin
            bcnt <= bcnt + 1;
        end
        if (!rd_q && rd_n) begin
            for (int d = 0; d < N_DEV; d++)
                if (!cs_n[d]) ch_ptr[d] <= ch_ptr[d] + 1;
        end
        busy <= (!stuck && bcnt >= 3 && bcnt < 25) ? '1 : '0;
    end

    always_comb begin
        db = '0;
        for (int d = 0; d < N_DEV; d++) begin
            frst[d] = (ch_ptr[d] == 0) && !(corrupt && d == 1);
            if (!cs_n[d] && ch_ptr[d] < N_CH) db = samp[d][ch_ptr[d]];
        end
    end

    // FIFO-side monitor
    logic [15:0] got [$];
    int wr_total = 0;
    int rd_low_total = 0;

    always @(negedge clk) begin
        if (wr) begin
            got.push_back(data);
            wr_total++;
        end
        if (!rd_n) rd_low_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input string tag, input logic [15:0] seq);
        logic [15:0] w [FLEN];
        logic [15:0] sum;
        logic [15:0] ew;
        int n = 0;
        int bad = 0;
        while (got.size() < FLEN && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_len"}, got.size(), FLEN);
        if (got.size() < FLEN) return;
        for (int i = 0; i < FLEN; i++) w[i] = got.pop_front();
        sum = seq;
        for (int d = 0; d < N_DEV; d++)
            for (int c = 0; c < N_CH; c++) sum += samp[d][c];
        for (int i = 0; i < FLEN; i++) begin
            if (i == 0) ew = 16'hAAAA;
            else if (i == 1) ew = seq;
            else if (i == FLEN - 1) ew = sum;
            else ew = samp[(i - 2) / N_CH][(i - 2) % N_CH];
            if (w[i] !== ew) bad++;
        end
        check({tag, "_seq"}, w[1], seq);
        check({tag, "_csum"}, w[FLEN-1], sum);
        check({tag, "_words"}, bad, 0);
    endtask

    task automatic pulse_ext();
        @(posedge clk);
        #1 ext = 1'b1;
        repeat (4) @(posedge clk);
        #1 ext = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_convst"}, convst, 1);
        check({tag, "_cs"}, cs_n, 2'b11);
        check({tag, "_rd"}, rd_n, 1);
        check({tag, "_wr"}, wr, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_drop"}, drop, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        logic [15:0] seq;
        int wr0;
        int rd0;
        int n;

        #2 reset_n = 1'b0;
        #1 check_reset_vals("rst");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // internal periodic triggers
        en = 1'b1;
        seq = 16'd0;
        for (int f = 0; f < 3; f++) begin
            expect_frame("int", seq);
            seq++;
        end
        en = 1'b0;
        check("int_drop", drop, 0);

        // external mode, FIFO one word short
        repeat (20) @(posedge clk);
        #1 mode = 1'b1;
        en = 1'b1;
        space = 10'd18;
        wr0 = wr_total;
        rd0 = rd_low_total;
        pulse_ext();
        repeat (300) @(posedge clk);
        check("sp_wr", wr_total - wr0, 0);
        check("sp_rd", rd_low_total - rd0, 0);
        check("sp_drop", drop, 1);
        seq++;
        #1 space = 10'd1023;
        pulse_ext();
        expect_frame("gap", seq);
        seq++;

        // second pulse lands during the read phase
        repeat (50) @(posedge clk);
        pulse_ext();
        repeat (60) @(posedge clk);
        pulse_ext();
        expect_frame("inflight", seq);
        seq++;
        repeat (20) @(posedge clk);
        check("miss_drop", drop, 2);
        pulse_ext();
        expect_frame("after_miss", seq);
        seq++;

        // busy never rises
        repeat (50) @(posedge clk);
        stuck = 1'b1;
        wr0 = wr_total;
        pulse_ext();
        repeat (BUSY_TO + 100) @(posedge clk);
        check("to_err0", err[0], 1);
        check("to_wr", wr_total - wr0, 0);
        check("to_convst", convst, 1);
        check("to_cs", cs_n, 2'b11);
        check("to_drop", drop, 2);
        seq++;
        stuck = 1'b0;
        pulse_ext();
        expect_frame("post_to", seq);
        seq++;
        check("post_to_err1", err[1], 0);

        // frstdata low on dev1 ch0
        repeat (50) @(posedge clk);
        corrupt = 1'b1;
        pulse_ext();
        expect_frame("frst", seq);
        seq++;
        corrupt = 1'b0;
        check("frst_err1", err[1], 1);

        // asynchronous reset in the middle of device reads
        repeat (50) @(posedge clk);
        pulse_ext();
        n = 0;
        while (cs_n === 2'b11 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("rst_reach", cs_n !== 2'b11, 1);
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check_reset_vals("mid_rst");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        got.delete();
        repeat (5) @(posedge clk);
        check("rel_drop", drop, 0);
        check("rel_err", err, 0);
        pulse_ext();
        expect_frame("post_rst", 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
